// File: rtl/pc_unit.sv
// pc_unit: 11-bit PIC16C57 program counter with return-stack strobes and a one-cycle flush bubble.
// Define PC_STACK_ERR_EN to build the sticky stack overflow/underflow flag (stk_err); otherwise it is tied 0.
module pc_unit #(
  parameter logic [10:0] RESET_VEC = 11'h7FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        ret_en,
  input  logic        call_en,
  input  logic        goto_en,
  input  logic        pcl_wr_en,
  input  logic        skip,
  input  logic [8:0]  lit,
  input  logic [7:0]  pcl_data,
  input  logic [1:0]  pa,
  input  logic [10:0] stack_out,
  output logic [10:0] PC_out,
  output logic        load_from_PC,
  output logic        load_from_stk1,
  output logic        load_from_stk2,
  output logic        flush,
  output logic [1:0]  depth,
  output logic        stk_err
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [10:0] pc_q, pc_d;
  logic [1:0]  depth_q, depth_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_VEC;
      depth_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
    end
  end

  // Strobes are gated by rst so an op held during reset never disturbs the stack.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    depth_d        = depth_q;
    load_from_PC   = 1'b0;
    load_from_stk1 = 1'b0;
    load_from_stk2 = 1'b0;
    if (ce && !rst) begin
      if (state_q == FLUSH) begin
        pc_d    = pc_q + 11'd1;
        state_d = RUN;
      end else begin
        state_d = FLUSH;
        if (ret_en) begin
          pc_d           = stack_out;
          load_from_stk2 = 1'b1;
          if (depth_q != 2'd0) depth_d = depth_q - 2'd1;
        end else if (call_en) begin
          pc_d           = {pa, 1'b0, lit[7:0]};
          load_from_PC   = 1'b1;
          load_from_stk1 = 1'b1;
          if (depth_q != 2'd2) depth_d = depth_q + 2'd1;
        end else if (goto_en) begin
          pc_d = {pa, lit};
        end else if (pcl_wr_en) begin
          pc_d = {pa, 1'b0, pcl_data};
        end else begin
          pc_d = pc_q + 11'd1;
          if (!skip) state_d = RUN;
        end
      end
    end
  end

  assign PC_out = pc_q;
  assign flush  = (state_q == FLUSH);
  assign depth  = depth_q;

`ifdef PC_STACK_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (load_from_stk2 && depth_q == 2'd0) | (load_from_PC && depth_q == 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign stk_err = err_q;
`else
  assign stk_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and randomized stimulus for pc_unit, scored against a queue of expected
// per-cycle outputs produced by an instruction-level model of the program counter.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        ret_en = 1'b0, call_en = 1'b0, goto_en = 1'b0, pcl_wr_en = 1'b0, skip = 1'b0;
  logic [8:0]  lit = '0;
  logic [7:0]  pcl_data = '0;
  logic [1:0]  pa = '0;
  logic [10:0] stack_out = '0;
  logic [10:0] PC_out;
  logic        load_from_PC, load_from_stk1, load_from_stk2, flush, stk_err;
  logic [1:0]  depth;

  pc_unit #(.RESET_VEC(11'h7FF)) dut (
    .clk(clk), .rst(rst), .ce(ce), .ret_en(ret_en), .call_en(call_en), .goto_en(goto_en),
    .pcl_wr_en(pcl_wr_en), .skip(skip), .lit(lit), .pcl_data(pcl_data), .pa(pa),
    .stack_out(stack_out), .PC_out(PC_out), .load_from_PC(load_from_PC),
    .load_from_stk1(load_from_stk1), .load_from_stk2(load_from_stk2), .flush(flush),
    .depth(depth), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [10:0] pc;
    logic        fl;
    logic [1:0]  dp;
    logic        err;
    logic        lpc, ls1, ls2;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  int   mPc = 2047;
  int   mDepth = 0;
  bit   mFlush = 0;
  bit   mErr = 0;
  bit   errBuilt;

  // Model state describes the instruction stream: what PC_out shows now, and what it becomes.
  task automatic applyStimulus(input bit r, input bit c, input bit rt, input bit cl, input bit gt,
                               input bit pw, input bit sk, input logic [8:0] l,
                               input logic [7:0] pd, input logic [1:0] p,
                               input logic [10:0] so, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ce = c; ret_en = rt; call_en = cl; goto_en = gt; pcl_wr_en = pw; skip = sk;
    lit = l; pcl_data = pd; pa = p; stack_out = so;
    if (r) begin
      mPc = 2047; mFlush = 0; mDepth = 0; mErr = 0;
    end
    e.tag = tag; e.pc = mPc[10:0]; e.fl = mFlush; e.dp = mDepth[1:0]; e.err = mErr;
    e.lpc = 0; e.ls1 = 0; e.ls2 = 0;
    if (!r && c) begin
      if (mFlush) begin
        mPc = (mPc + 1) % 2048;
        mFlush = 0;
      end else begin
        mFlush = 1;
        if (rt) begin
          e.ls2 = 1;
          mPc = int'(so);
          if (mDepth == 0) begin
            if (errBuilt) mErr = 1;
          end else mDepth = mDepth - 1;
        end else if (cl) begin
          e.lpc = 1; e.ls1 = 1;
          mPc = int'(p) * 512 + int'(l) % 256;
          if (mDepth == 2) begin
            if (errBuilt) mErr = 1;
          end else mDepth = mDepth + 1;
        end else if (gt) begin
          mPc = int'(p) * 512 + int'(l);
        end else if (pw) begin
          mPc = int'(p) * 512 + int'(pd);
        end else begin
          mPc = (mPc + 1) % 2048;
          mFlush = sk;
        end
      end
    end
    expQ.push_back(e);
  endtask

  task automatic idle(input string tag);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 9'h0, 8'h0, 2'b00, 11'h0, tag);
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (PC_out !== e.pc || flush !== e.fl || depth !== e.dp || stk_err !== e.err ||
        load_from_PC !== e.lpc || load_from_stk1 !== e.ls1 || load_from_stk2 !== e.ls2) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got pc=%h flush=%b depth=%0d err=%b strobes(PC,stk1,stk2)=%b%b%b; expected pc=%h flush=%b depth=%0d err=%b strobes=%b%b%b",
               e.tag, $time, PC_out, flush, depth, stk_err, load_from_PC, load_from_stk1,
               load_from_stk2, e.pc, e.fl, e.dp, e.err, e.lpc, e.ls1, e.ls2);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
`ifdef PC_STACK_ERR_EN
    errBuilt = 1;
`else
    errBuilt = 0;
`endif
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 9'h1FF, 8'h0, 2'b11, 11'h0, "resetHeld");
    for (int i = 0; i < 6; i++) idle("countUp");
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 9'h034, 8'h0, 2'b01, 11'h0, "callAt005");
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 9'h1FF, 8'h0, 2'b11, 11'h0, "flushIgnoresGoto");
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 9'h0, 8'h0, 2'b00, 11'h006, "retDepth1");
    idle("retFlush");
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 9'h0, 8'h0, 2'b00, 11'h123, "retDepth0");
    idle("retFlush2");
    applyStimulus(0, 1, 0, 1, 1, 0, 0, 9'h0AB, 8'h0, 2'b10, 11'h0, "callBeatsGoto");
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 9'h155, 8'h0, 2'b01, 11'h0, "gotoIgnoredInFlush");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 1, 0, 0, 0, 9'h010 + 9'(i), 8'h0, 2'b00, 11'h0, "callSaturate");
      idle("callSaturateFlush");
    end
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 9'h0, 8'h9C, 2'b11, 11'h0, "pclWrite");
    idle("pclFlush");
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 9'h0, 8'h0, 2'b00, 11'h0, "skip");
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 1, 1, 0, 0, 0, 9'h0, 8'h0, 2'b00, 11'h3AA, "stallMidFlush");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 9'h0, 8'h0, 2'b00, 11'h0, "resetFromFlush");
    idle("afterReset");
    for (int i = 0; i < 3000; i++) begin
      bit r, c;
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 7) != 0);
      applyStimulus(r, c, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 3) == 0, 9'($urandom), 8'($urandom), 2'($urandom),
                    11'($urandom), "random");
    end
    @(posedge clk);
    #1;
    rst = 0; ce = 0;
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expected vectors never checked, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- 11-bit program counter for the PIC16C57 core; sits directly upstream of the 2-level return stack.
- Drives PC_out to the stack and the program ROM. Consumes stack_out on returns.
- Generates the stack load strobes: load_from_PC, load_from_stk1, load_from_stk2.
- Inserts a one-cycle flush bubble after every taken branch or skip, and tracks stack depth.

Parameters:
- RESET_VEC, 11'h7FF, PC value on reset (PIC16C57 reset vector).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ce  in  1  instruction-cycle enable; 0 = full stall
- ret_en  in  1  RETLW executing
- call_en  in  1  CALL executing
- goto_en  in  1  GOTO executing
- pcl_wr_en  in  1  ALU write to PCL (computed goto)
- skip  in  1  skip condition true (BTFSS/DECFSZ etc.)
- lit  in  9  instruction literal field
- pcl_data  in  8  ALU result written to PCL
- pa  in  2  STATUS<6:5> page bits
- stack_out  in  11  top of return stack
- PC_out  out  11  current PC (next fetch address)
- load_from_PC  out  1  stack strobe: stack1 <= PC_out
- load_from_stk1  out  1  stack strobe: stack2 <= stack1
- load_from_stk2  out  1  stack strobe: stack1 <= stack2
- flush  out  1  current fetched instruction is discarded (bubble)
- depth  out  2  valid stack entries, 0..2
- stk_err  out  1  sticky stack overflow/underflow (see Optional Feature)

Behaviour:
- Reset (async, rst=1): PC_out=RESET_VEC, state=RUN, flush=0, depth=0, stk_err=0, all strobes 0. Reset mid-FLUSH returns to RUN.
- States: RUN, FLUSH. flush=1 exactly when state=FLUSH.
- ce=0: PC, state, depth and stk_err hold; all strobes 0.
- ce=1 in FLUSH:
  - All op inputs are ignored and strobes are 0.
  - PC <= PC+1; state -> RUN.
- ce=1 in RUN, fixed priority ret > call > goto > pcl_wr > skip > none:
  - ret: PC <= stack_out; load_from_stk2=1; depth <= max(depth-1,0); -> FLUSH.
  - call: PC <= {pa, 1'b0, lit[7:0]}; load_from_PC=1 and load_from_stk1=1 in the same cycle. The stack captures the pre-edge PC_out, which is the return address. depth <= min(depth+1,2); -> FLUSH.
  - goto: PC <= {pa, lit[8:0]}; -> FLUSH.
  - pcl_wr: PC <= {pa, 1'b0, pcl_data}; -> FLUSH.
  - skip: PC <= PC+1; -> FLUSH.
  - none: PC <= PC+1; stay in RUN.
- Strobes are combinational from the accepted op and are valid in the same cycle. They are never asserted while ce=0, in FLUSH, or during reset.
- PC arithmetic: 11-bit wrap, 11'h7FF+1 = 11'h000. No carry into pa.
- Return at depth 0: still loads stack_out (silicon behaviour); depth stays 0.
- Call at depth 2: the oldest entry is overwritten (stack2 <= stack1); depth stays 2.
- Latency: a branch target appears on PC_out one clock after the op cycle. The first valid instruction from the target fetch executes two cycles after the branch.

Optional Feature:
- Macro: PC_STACK_ERR_EN.
- Defined: stk_err is set on any accepted call at depth=2 or accepted ret at depth=0. It is sticky and cleared only by rst.
- Undefined: stk_err is tied 0 and no error logic is built. The port is still present.

Test Plan:
- Reset then 3 cycles ce=1, no ops: PC_out 7FF -> 000 -> 001 -> 002; flush=0 throughout.
- PC=005, call_en=1, lit=9'h034, pa=2'b01: load_from_PC=load_from_stk1=1 in that cycle; next PC=11'h234; flush=1 one cycle; depth=1; stack captured 005.
- ret_en=1 with stack_out=11'h006, depth=1: load_from_stk2=1; next PC=006; flush=1; depth=0. Then a second ret gives depth=0 and, with PC_STACK_ERR_EN, stk_err=1.
- call_en=1 and goto_en=1 together: call wins. In the following FLUSH cycle, goto_en=1 is ignored and PC increments.
- Three consecutive calls (with flush cycles between): depth saturates at 2; stk_err=1 only when built with PC_STACK_ERR_EN.
- ce=0 for 4 cycles mid-FLUSH, then assert rst: PC held, no strobes; on rst PC=7FF, state RUN, flush=0.
